// File: rtl/inst_cache_assoc.sv
// 2-way set-associative instruction cache with zero-latency lookup, fill bypass
// and a one-set-per-cycle flush walker. Optional macro ICACHE_STATS_EN adds hit/miss counters.
module inst_cache_assoc #(
  parameter int INDEX_BITS  = 7,
  parameter int TAG_BITS    = 10,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        rdy_i,
  input  logic        we_i,
  input  logic [31:0] write_pc_i,
  input  logic [31:0] write_inst_i,
  input  logic        rd_en_i,
  input  logic [31:0] read_pc_i,
  input  logic        flush_i,
  output logic        hit_o,
  output logic [31:0] inst_o,
  output logic        busy_o,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
);

  localparam int SETS = 1 << INDEX_BITS;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]            state_q;
  logic [INDEX_BITS-1:0] flush_idx_q;
  logic [1:0]            valid_q [SETS];
  logic [SETS-1:0]       lru_q;
  logic [TAG_BITS-1:0]   tag_mem  [2][SETS];
  logic [31:0]           data_mem [2][SETS];

  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic [TAG_BITS-1:0]   rd_tag, wr_tag;
  logic [1:0]            way_hit;
  logic                  hit_way, fill_way, bypass, active, is_idle;
  logic                  do_fill, do_touch;
  logic                  unused_pc;

  assign rd_idx  = read_pc_i[OFFSET_BITS +: INDEX_BITS];
  assign rd_tag  = read_pc_i[OFFSET_BITS+INDEX_BITS +: TAG_BITS];
  assign wr_idx  = write_pc_i[OFFSET_BITS +: INDEX_BITS];
  assign wr_tag  = write_pc_i[OFFSET_BITS+INDEX_BITS +: TAG_BITS];
  assign unused_pc = ^{read_pc_i, write_pc_i};

  assign is_idle = (state_q == ST_IDLE);
  assign active  = rstn_i && rdy_i && is_idle;
  assign bypass  = we_i && is_idle && (wr_idx == rd_idx) && (wr_tag == rd_tag);
  assign busy_o  = (state_q == ST_FLUSH);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    way_hit = '0;
    for (int w = 0; w < 2; w++) begin
      way_hit[w] = valid_q[rd_idx][w] && (tag_mem[w][rd_idx] == rd_tag);
    end
    hit_way = !way_hit[0];
    hit_o   = active && (bypass || (|way_hit));
    inst_o  = '0;
    if (active) begin
      if (bypass)          inst_o = write_inst_i;
      else if (way_hit[0]) inst_o = data_mem[0][rd_idx];
      else if (way_hit[1]) inst_o = data_mem[1][rd_idx];
    end
  end

  // Victim choice: refresh a matching line, else fill an empty way, else evict the LRU way.
  always_comb begin
    fill_way = lru_q[wr_idx];
    if (valid_q[wr_idx][0] && (tag_mem[0][wr_idx] == wr_tag))      fill_way = 1'b0;
    else if (valid_q[wr_idx][1] && (tag_mem[1][wr_idx] == wr_tag)) fill_way = 1'b1;
    else if (!valid_q[wr_idx][0])                                  fill_way = 1'b0;
    else if (!valid_q[wr_idx][1])                                  fill_way = 1'b1;
  end

  assign do_fill  = rstn_i && rdy_i && is_idle && we_i && !flush_i;
  assign do_touch = rdy_i && is_idle && rd_en_i && !bypass && (|way_hit) && !flush_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      flush_idx_q <= '0;
      lru_q       <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (rdy_i) begin
      case (state_q)
        ST_IDLE: begin
          if (flush_i) begin
            state_q <= ST_FLUSH;
          end else begin
            if (do_touch) lru_q[rd_idx] <= ~hit_way;
            // Fill follows the touch so it wins when both hit the same set.
            if (we_i) begin
              valid_q[wr_idx][fill_way] <= 1'b1;
              lru_q[wr_idx]             <= ~fill_way;
            end
          end
        end
        default: begin
          valid_q[flush_idx_q] <= '0;
          lru_q[flush_idx_q]   <= 1'b0;
          flush_idx_q          <= flush_idx_q + 1'b1;
          if (flush_idx_q == '1) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether a line is live.
  always_ff @(posedge clk_i) begin
    if (do_fill) begin
      tag_mem[fill_way][wr_idx]  <= wr_tag;
      data_mem[fill_way][wr_idx] <= write_inst_i;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        lookup;

  assign lookup = rdy_i && is_idle && rd_en_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (lookup) begin
      if (hit_o) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_inst_cache_assoc.sv
// Self-checking bench for inst_cache_assoc: a per-set recency-list model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_inst_cache_assoc;

  localparam int SETS = 128;
`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        rdy_i = 1'b1;
  logic        we_i = 1'b0;
  logic [31:0] write_pc_i = '0;
  logic [31:0] write_inst_i = '0;
  logic        rd_en_i = 1'b0;
  logic [31:0] read_pc_i = '0;
  logic        flush_i = 1'b0;
  logic        hit_o;
  logic [31:0] inst_o;
  logic        busy_o;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  inst_cache_assoc dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .rdy_i(rdy_i), .we_i(we_i),
    .write_pc_i(write_pc_i), .write_inst_i(write_inst_i),
    .rd_en_i(rd_en_i), .read_pc_i(read_pc_i), .flush_i(flush_i),
    .hit_o(hit_o), .inst_o(inst_o), .busy_o(busy_o),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each set is a recency list, entry 0 most recent, at most two lines.
  int          n_ent [SETS];
  logic [9:0]  mtag  [SETS][2];
  logic [31:0] mdat  [SETS][2];
  bit          m_busy = 1'b0;
  int          flush_left = 0;
  int          m_hits = 0, m_misses = 0;

  function automatic int idx_of(input logic [31:0] pc); return int'((pc >> 2) & 32'h7F); endfunction
  function automatic logic [9:0] tag_of(input logic [31:0] pc); return 10'((pc >> 9) & 32'h3FF); endfunction

  function automatic int m_find(input int s, input logic [9:0] t);
    for (int i = 0; i < n_ent[s]; i++) if (mtag[s][i] == t) return i;
    return -1;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) n_ent[s] = 0;
  endfunction

  function automatic void m_promote(input int s, input int i);
    logic [9:0] t; logic [31:0] d;
    if (i == 1) begin
      t = mtag[s][0]; d = mdat[s][0];
      mtag[s][0] = mtag[s][1]; mdat[s][0] = mdat[s][1];
      mtag[s][1] = t; mdat[s][1] = d;
    end
  endfunction

  function automatic bit m_bypass();
    return we_i && !m_busy && idx_of(write_pc_i) == idx_of(read_pc_i) && tag_of(write_pc_i) == tag_of(read_pc_i);
  endfunction

  initial m_clear();

  always @(posedge clk_i) begin
    int s, i, ws, wi;
    bit byp;
    if (!rstn_i) begin
      m_clear(); m_busy = 0; flush_left = 0; m_hits = 0; m_misses = 0;
    end else if (rdy_i) begin
      if (m_busy) begin
        flush_left--;
        if (flush_left == 0) m_busy = 0;
      end else begin
        s = idx_of(read_pc_i);
        i = m_find(s, tag_of(read_pc_i));
        byp = m_bypass();
        if (rd_en_i) begin
          if (byp || i >= 0) m_hits++; else m_misses++;
        end
        if (flush_i) begin
          m_busy = 1; flush_left = SETS; m_clear();
        end else begin
          if (rd_en_i && !byp && i >= 0) m_promote(s, i);
          if (we_i) begin
            ws = idx_of(write_pc_i);
            wi = m_find(ws, tag_of(write_pc_i));
            if (wi >= 0) begin
              mdat[ws][wi] = write_inst_i;
              m_promote(ws, wi);
            end else begin
              mtag[ws][1] = mtag[ws][0]; mdat[ws][1] = mdat[ws][0];
              mtag[ws][0] = tag_of(write_pc_i); mdat[ws][0] = write_inst_i;
              if (n_ent[ws] < 2) n_ent[ws]++;
            end
          end
        end
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    int s, i;
    bit act, byp;
    logic [31:0] e_inst;
    if (cmp_en) begin
      s = idx_of(read_pc_i);
      i = m_find(s, tag_of(read_pc_i));
      byp = m_bypass();
      act = rstn_i && rdy_i && !m_busy;
      e_inst = '0;
      if (act) begin
        if (byp) e_inst = write_inst_i;
        else if (i >= 0) e_inst = mdat[s][i];
      end
      check("model_hit", 32'(hit_o), 32'(act && (byp || i >= 0)));
      check("model_inst", inst_o, e_inst);
      check("model_busy", 32'(busy_o), 32'(m_busy));
      check("model_hit_cnt", hit_cnt_o, STATS ? 32'(m_hits) : 32'd0);
      check("model_miss_cnt", miss_cnt_o, STATS ? 32'(m_misses) : 32'd0);
    end
  end

  task automatic step(); @(posedge clk_i); #1; endtask

  task automatic drive(input bit we, input logic [31:0] wpc, input logic [31:0] wd,
                       input bit rd, input logic [31:0] rpc);
    we_i = we; write_pc_i = wpc; write_inst_i = wd; rd_en_i = rd; read_pc_i = rpc;
  endtask

  task automatic do_reset();
    rstn_i = 0; flush_i = 0; rdy_i = 1; drive(0, 0, 0, 0, 0);
    step(); step();
    rstn_i = 1;
  endtask

  task automatic expect_read(input string name, input logic [31:0] pc, input bit h, input logic [31:0] d);
    drive(0, 0, 0, 1, pc); #1;
    check({name, "_hit"}, 32'(hit_o), 32'(h));
    check({name, "_inst"}, inst_o, d);
    step();
  endtask

  initial begin
    int busy_cycles;
    do_reset();
    cmp_en = 1;
    #1;
    check("reset_hit", 32'(hit_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_hit_cnt", hit_cnt_o, 32'd0);

    // Fill then read back; another tag in the same set misses.
    drive(1, 32'h104, 32'hAAAA0001, 0, 0); step();
    expect_read("fill_rd_104", 32'h104, 1, 32'hAAAA0001);
    expect_read("fill_rd_304", 32'h304, 0, 32'h0);

    // LRU eviction: touched line survives, untouched one is replaced.
    do_reset();
    drive(1, 32'h104, 32'h11, 0, 0); step();
    drive(1, 32'h304, 32'h22, 0, 0); step();
    drive(0, 0, 0, 1, 32'h104); step();
    drive(1, 32'h504, 32'h33, 0, 0); step();
    expect_read("lru_304", 32'h304, 0, 32'h0);
    expect_read("lru_104", 32'h104, 1, 32'h11);
    expect_read("lru_504", 32'h504, 1, 32'h33);

    // Same-cycle bypass on an empty cache.
    do_reset();
    drive(1, 32'h208, 32'hDEADBEEF, 1, 32'h208); #1;
    check("byp_hit", 32'(hit_o), 32'd1);
    check("byp_inst", inst_o, 32'hDEADBEEF);
    step();
    drive(1, 32'h208, 32'hDEADBEEF, 1, 32'h408); #1;
    check("byp_other_tag", 32'(hit_o), 32'd0);
    step();

    // Full flush: 128 busy cycles, fills dropped, no hits, lines gone afterwards.
    do_reset();
    drive(1, 32'h000, 32'h55, 0, 0); step();
    drive(1, 32'h1FC, 32'h66, 0, 0); step();
    expect_read("pre_fl_00", 32'h000, 1, 32'h55);
    drive(0, 0, 0, 0, 32'h1FC); flush_i = 1; step();
    flush_i = 0;
    drive(1, 32'h000, 32'h77, 1, 32'h000);
    busy_cycles = 0;
    for (int k = 0; k < 300; k++) begin
      #1;
      if (!busy_o) break;
      busy_cycles++;
      if (hit_o !== 1'b0) check("flush_hit", 32'(hit_o), 32'd0);
      step();
    end
    drive(0, 0, 0, 0, 0);
    check("flush_len", 32'(busy_cycles), 32'd128);
    step();
    expect_read("post_fl_00", 32'h000, 0, 32'h0);
    expect_read("post_fl_7f", 32'h1FC, 0, 32'h0);

    // Flush stalled by rdy_i low for 10 cycles, then reset aborting a flush.
    do_reset();
    drive(1, 32'h104, 32'h99, 0, 0); step();
    drive(0, 0, 0, 0, 0); flush_i = 1; step();
    flush_i = 0;
    busy_cycles = 0;
    for (int k = 0; k < 400; k++) begin
      rdy_i = !(k >= 50 && k < 60);
      #1;
      if (!busy_o) break;
      busy_cycles++;
      step();
    end
    rdy_i = 1;
    check("stall_flush_len", 32'(busy_cycles), 32'd138);
    step();
    flush_i = 1; step();
    flush_i = 0;
    for (int k = 0; k < 20; k++) step();
    rstn_i = 0; step();
    check("rst_abort_busy", 32'(busy_o), 32'd0);
    rstn_i = 1;
    expect_read("rst_abort_rd", 32'h104, 0, 32'h0);

    // Statistics: 3 hits (one by bypass), 2 misses.
    do_reset();
    drive(1, 32'h104, 32'h11, 0, 0); step();
    drive(0, 0, 0, 1, 32'h104); step();
    drive(0, 0, 0, 1, 32'h104); step();
    drive(0, 0, 0, 1, 32'h304); step();
    drive(0, 0, 0, 1, 32'h504); step();
    drive(1, 32'h700, 32'h5A, 1, 32'h700); step();
    drive(0, 0, 0, 0, 0); #1;
    check("stats_hits", hit_cnt_o, STATS ? 32'd3 : 32'd0);
    check("stats_misses", miss_cnt_o, STATS ? 32'd2 : 32'd0);
    step(); step();

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_cache_assoc.md
INST_CACHE_ASSOC -- requirements
Module: inst_cache_assoc

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 7, meaning set-index width (sets = 2^INDEX_BITS).
REQ-002 SHALL have parameter TAG_BITS, default 10, meaning stored tag width.
REQ-003 SHALL have parameter OFFSET_BITS, default 2, meaning low PC bits ignored (index = pc[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS], tag = next TAG_BITS bits).
REQ-004 SHALL have ports: clk_i  in  1  clock (all state changes on its rising edge).
REQ-005 rstn_i  in  1  reset; one clock; reset is synchronous and active-low.
REQ-006 rdy_i  in  1  global ready; when low, all state holds.
REQ-007 we_i  in  1  fill request; write_pc_i  in  32  fill address; write_inst_i  in  32  fill data.
REQ-008 rd_en_i  in  1  lookup valid (stats only); read_pc_i  in  32  lookup address.
REQ-009 flush_i  in  1  start full invalidation.
REQ-010 hit_o  out  1  lookup hit; inst_o  out  32  hit data, else zero.
REQ-011 busy_o  out  1  flush in progress.
REQ-012 hit_cnt_o  out  32, miss_cnt_o  out  32: lookup statistics.

Function
REQ-013 Storage SHALL be 2-way set-associative: per set, per way valid, tag, 32-bit data; one LRU bit per set (0 = way0 is victim).
REQ-014 Lookup SHALL be combinational, zero latency: hit_o=1 when a valid way in the read set holds the read tag; inst_o = that way's data.
REQ-015 Bypass: when we_i=1, state IDLE, and write index and tag both equal read index and tag, hit_o=1 and inst_o=write_inst_i regardless of stored contents.
REQ-016 hit_o=0 and inst_o=0 whenever rstn_i=0, rdy_i=0, or state FLUSH.
REQ-017 Fill (we_i=1, rdy_i=1, IDLE) SHALL write one way at the next edge; way choice: way already holding the same valid tag; else first invalid way (way0 before way1); else LRU victim.
REQ-018 After a fill, LRU of that set SHALL point to the way not written.
REQ-019 A non-bypass read hit with rd_en_i=1, rdy_i=1, IDLE SHALL set LRU to the way not hit; if a fill targets the same set in the same cycle, the fill's LRU update wins.
REQ-020 FSM states IDLE, FLUSH; IDLE->FLUSH when flush_i=1 and rdy_i=1; flush_i has priority over a simultaneous we_i, which is dropped.
REQ-021 In FLUSH, a set counter starting at 0 SHALL clear both valid bits and the LRU bit of one set per cycle with rdy_i=1; counter wraps 2^INDEX_BITS-1 -> 0 and state returns to IDLE on that edge; flush length = 2^INDEX_BITS ready cycles.
REQ-022 In FLUSH, we_i and flush_i SHALL be ignored; busy_o=1 exactly while state is FLUSH.
REQ-023 rdy_i=0 in FLUSH SHALL freeze the counter without clearing.

Reset
REQ-024 rstn_i=0 at an edge SHALL clear all valid and LRU bits in that cycle, set state IDLE, counter 0, counters 0, aborting any flush; tags and data need not reset.
REQ-025 Reset SHALL take priority over rdy_i, flush_i and we_i.

Configuration
REQ-026 Macro ICACHE_STATS_EN: when defined, hit_cnt_o/miss_cnt_o count lookups (rd_en_i=1, rdy_i=1, IDLE) as hit (bypass included) or miss, saturating at 0xFFFF_FFFF; when undefined, no counter registers exist and both outputs are constant zero.

Verification (defaults; set 0x41 = pc 0x104/0x304/0x504, tags 0/1/2)
REQ-027 Reset, fill pc 0x104 data 0xAAAA0001, next cycle read 0x104 -> hit_o=1, inst_o=0xAAAA0001; read 0x304 -> hit_o=0, inst_o=0.
REQ-028 Fill 0x104 (0x11), 0x304 (0x22), read 0x104, fill 0x504 (0x33) -> 0x304 evicted (miss), 0x104=0x11 and 0x504=0x33 hit.
REQ-029 Read 0x208 with we_i=1 same pc data 0xDEADBEEF, empty cache -> same-cycle hit_o=1, inst_o=0xDEADBEEF; read 0x408 same set other tag -> hit_o=0.
REQ-030 Fill sets 0x00 and 0x7F, pulse flush_i -> busy_o=1 for 128 ready cycles, we_i during flush dropped, hit_o=0 throughout; afterwards both lines miss.
REQ-031 Start flush, hold rdy_i=0 for 10 cycles mid-flush -> busy_o total 138 cycles; assert rstn_i=0 mid-flush -> busy_o=0 next cycle, all lookups miss.
REQ-032 ICACHE_STATS_EN defined: 3 hits, 2 misses with rd_en_i=1 -> hit_cnt_o=3, miss_cnt_o=2; undefined -> both 0.
